// File: rtl/tvm_vpi_ram_copy_engine.sv
// tvm_vpi_ram_copy_engine
// Initiator for the tvm_vpi_ram control/stream interface. A single copy
// command (src, dst, size) is turned into one read request and one write
// request pulse. The read stream is then forwarded word by word into the
// write stream. A stall watchdog aborts a transfer that stops making progress.
module tvm_vpi_ram_copy_engine #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src_addr,
  input  logic [31:0]      cmd_dst_addr,
  input  logic [31:0]      cmd_size,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ctrl_read_req,
  output logic [31:0]      ctrl_read_addr,
  output logic [31:0]      ctrl_read_size,
  output logic             ctrl_write_req,
  output logic [31:0]      ctrl_write_addr,
  output logic [31:0]      ctrl_write_size,
  input  logic [WIDTH-1:0] read_data,
  input  logic             read_valid,
  output logic             read_dequeue,
  output logic             write_enable,
  output logic [WIDTH-1:0] write_data,
  input  logic             write_full
);

  // Stall counter only has to reach TIMEOUT.
  localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_COPY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          init_q;          // low until the first edge after reset
  logic [31:0]   src_q,  src_d;
  logic [31:0]   dst_q,  dst_d;
  logic [31:0]   size_q, size_d;
  logic [31:0]   cnt_q,  cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          done_q, done_d;
  logic          err_q,  err_d;
  // Marks the done cycle of a zero-size command: the engine stays in IDLE
  // but reports busy for that one cycle and does not take a new command.
  logic          zero_q, zero_d;

  logic          in_copy_s;
  logic          xfer_s;
  logic          accept_s;
  logic          last_s;
  logic          stall_hit_s;

  // Stream handshake and command acceptance decode.
  always_comb begin
    in_copy_s   = (state_q == S_COPY);
    xfer_s      = in_copy_s & read_valid & ~write_full;
    cmd_ready   = (state_q == S_IDLE) & init_q & ~zero_q;
    accept_s    = cmd_valid & cmd_ready;
    last_s      = xfer_s & ((cnt_q + 32'd1) == size_q);
    stall_hit_s = in_copy_s & ~xfer_s & (stall_q == SW'(TIMEOUT - 1));
  end

  // Next-state, counter and completion-pulse logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    zero_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          src_d   = cmd_src_addr;
          dst_d   = cmd_dst_addr;
          size_d  = cmd_size;
          cnt_d   = 32'd0;
          stall_d = '0;
          if (cmd_size == 32'd0) begin
            // Nothing to move: finish without touching the RAM.
            done_d = 1'b1;
            zero_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        state_d = S_COPY;
      end
      S_COPY: begin
        if (xfer_s) begin
          cnt_d   = cnt_q + 32'd1;
          stall_d = '0;
          if (last_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_COPY;
          end
        end else if (stall_hit_s) begin
          // Transfer hung: give up, partial data is left where it landed.
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      size_q  <= 32'd0;
      cnt_q   <= 32'd0;
      stall_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      src_q   <= src_d;
      dst_q   <= dst_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  // Output drive: pulses come from registers, stream controls follow xfer.
  always_comb begin
    busy            = (state_q != S_IDLE) | zero_q;
    done            = done_q;
    err             = err_q;
    ctrl_read_req   = (state_q == S_REQ);
    ctrl_write_req  = (state_q == S_REQ);
    ctrl_read_addr  = src_q;
    ctrl_read_size  = size_q;
    ctrl_write_addr = dst_q;
    ctrl_write_size = size_q;
    read_dequeue    = xfer_s;
    write_enable    = xfer_s;
    if (in_copy_s) begin
      write_data = read_data;
    end else begin
      write_data = {WIDTH{1'b0}};
    end
  end

endmodule
